branch_resolve_ctrl: RTL and testbench

- Sequences the shared branch comparator in the RV32I execute stage.
- Accepts one branch or jump per transaction from EX and latches its operands.
- Drives the external combinational comparator from those latched operands, decodes funct3 against the less/equal result, and computes the target.
- Issues a PC redirect plus a fixed-length pipeline flush, and stalls upstream for the whole transaction.

---
 rtl/branch_resolve_ctrl_if.sv | 42 ++++
 rtl/branch_resolve_ctrl.sv | 179 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Request, comparator and resolution signals of the execute-stage branch resolver.
// The slave modport is the resolver; the master modport is the EX stage plus comparator.
interface branch_resolve_ctrl_if;
    logic        valid_i;
    logic        ready_o;
    logic        is_branch_i;
    logic        is_jal_i;
    logic        is_jalr_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        kill_i;
    logic [31:0] cmp_rs1_o;
    logic [31:0] cmp_rs2_o;
    logic        cmp_unsign_o;
    logic        cmp_less_i;
    logic        cmp_equal_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [31:0] link_o;
    logic        link_we_o;
    logic        resolved_o;
    logic        misalign_o;
    logic        illegal_o;

    modport master (
        output valid_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i, pc_i, imm_i,
               rs1_data_i, rs2_data_i, kill_i, cmp_less_i, cmp_equal_i,
        input  ready_o, cmp_rs1_o, cmp_rs2_o, cmp_unsign_o, redirect_o, redirect_pc_o,
               flush_o, link_o, link_we_o, resolved_o, misalign_o, illegal_o
    );

    modport slave (
        input  valid_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i, pc_i, imm_i,
               rs1_data_i, rs2_data_i, kill_i, cmp_less_i, cmp_equal_i,
        output ready_o, cmp_rs1_o, cmp_rs2_o, cmp_unsign_o, redirect_o, redirect_pc_o,
               flush_o, link_o, link_we_o, resolved_o, misalign_o, illegal_o
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// RV32I branch/jump resolver: latches one control transfer, evaluates it against the shared
// comparator, then issues redirect + link writeback and holds a fixed-length front-end flush.
module branch_resolve_ctrl #(
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned RESET_PC_ALIGN = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    branch_resolve_ctrl_if.slave brc_io
);

    typedef enum logic [1:0] {StIdle, StEval, StFlush} state_e;

    localparam logic [31:0] AlignMask = (32'h1 << RESET_PC_ALIGN) - 32'h1;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, imm_q, rs1_q, rs2_q;
    logic [2:0]  funct3_q;
    logic        is_branch_q, is_jal_q, is_jalr_q;

    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] link_q, link_d;
    logic        link_we_q, link_we_d;
    logic        resolved_q, resolved_d;
    logic        misalign_q, misalign_d;
    logic        illegal_q, illegal_d;

    logic        accept;
    logic        illegal;
    logic        cond;
    logic        taken;
    logic        misalign;
    logic [31:0] target;

    assign accept = brc_io.valid_i & (state_q == StIdle) & ~brc_io.kill_i &
                    (brc_io.is_branch_i | brc_io.is_jal_i | brc_io.is_jalr_i);

    assign illegal = is_branch_q & (funct3_q[2:1] == 2'b01);

    always_comb begin
        cond = 1'b0;
        case (funct3_q)
            3'b000:  cond = brc_io.cmp_equal_i;
            3'b001:  cond = ~brc_io.cmp_equal_i;
            3'b100,
            3'b110:  cond = brc_io.cmp_less_i;
            3'b101,
            3'b111:  cond = ~brc_io.cmp_less_i;
            default: cond = 1'b0;
        endcase
    end

    assign taken    = is_jal_q | is_jalr_q | (is_branch_q & cond);
    assign target   = is_jalr_q ? ((rs1_q + imm_q) & ~32'h1) : (pc_q + imm_q);
    assign misalign = |(target & AlignMask);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StEval;
            end
            StEval: begin
                state_d = StIdle;
                if (!brc_io.kill_i && !illegal && taken && !misalign) begin
                    state_d = StFlush;
                    cnt_d   = 3'(FLUSH_CYCLES);
                end
            end
            StFlush: begin
                cnt_d = cnt_q - 3'd1;
                if (brc_io.kill_i || cnt_q <= 3'd1) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output logic: next values of the registered result pulses
    always_comb begin
        redirect_d    = 1'b0;
        link_we_d     = 1'b0;
        resolved_d    = 1'b0;
        misalign_d    = 1'b0;
        illegal_d     = 1'b0;
        redirect_pc_d = redirect_pc_q;
        link_d        = link_q;
        if (state_q == StEval && !brc_io.kill_i) begin
            resolved_d = 1'b1;
            if (illegal) begin
                illegal_d = 1'b1;
            end else if (taken) begin
                // Target is exposed even when misaligned so the trap handler can report it.
                redirect_pc_d = target;
                if (misalign) begin
                    misalign_d = 1'b1;
                end else begin
                    redirect_d = 1'b1;
                    if (is_jal_q || is_jalr_q) begin
                        link_we_d = 1'b1;
                        link_d    = pc_q + 32'd4;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q          <= 32'h0;
            imm_q         <= 32'h0;
            rs1_q         <= 32'h0;
            rs2_q         <= 32'h0;
            funct3_q      <= 3'h0;
            is_branch_q   <= 1'b0;
            is_jal_q      <= 1'b0;
            is_jalr_q     <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
            link_q        <= 32'h0;
            link_we_q     <= 1'b0;
            resolved_q    <= 1'b0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            if (accept) begin
                pc_q        <= brc_io.pc_i;
                imm_q       <= brc_io.imm_i;
                rs1_q       <= brc_io.rs1_data_i;
                rs2_q       <= brc_io.rs2_data_i;
                funct3_q    <= brc_io.funct3_i;
                is_branch_q <= brc_io.is_branch_i;
                is_jal_q    <= brc_io.is_jal_i;
                is_jalr_q   <= brc_io.is_jalr_i;
            end
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            link_q        <= link_d;
            link_we_q     <= link_we_d;
            resolved_q    <= resolved_d;
            misalign_q    <= misalign_d;
            illegal_q     <= illegal_d;
        end
    end

    assign brc_io.ready_o       = (state_q == StIdle);
    assign brc_io.flush_o       = (state_q == StFlush);
    assign brc_io.cmp_rs1_o     = rs1_q;
    assign brc_io.cmp_rs2_o     = rs2_q;
    assign brc_io.cmp_unsign_o  = funct3_q[1];
    assign brc_io.redirect_o    = redirect_q;
    assign brc_io.redirect_pc_o = redirect_pc_q;
    assign brc_io.link_o        = link_q;
    assign brc_io.link_we_o     = link_we_q;
    assign brc_io.resolved_o    = resolved_q;
    assign brc_io.misalign_o    = misalign_q;
    assign brc_io.illegal_o     = illegal_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: expected outcomes queued at issue, compared at
// resolution; a second instance with a 3-cycle flush covers kill during FLUSH.
module tb_branch_resolve_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_ctrl_if bus_a ();
    branch_resolve_ctrl_if bus_b ();

    branch_resolve_ctrl #(.FLUSH_CYCLES(2), .RESET_PC_ALIGN(2)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .brc_io(bus_a)
    );

    branch_resolve_ctrl #(.FLUSH_CYCLES(3), .RESET_PC_ALIGN(2)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .brc_io(bus_b)
    );

    // Behavioural comparator
    assign bus_a.cmp_equal_i = (bus_a.cmp_rs1_o == bus_a.cmp_rs2_o);
    assign bus_a.cmp_less_i  = bus_a.cmp_unsign_o ? (bus_a.cmp_rs1_o < bus_a.cmp_rs2_o)
                                                  : ($signed(bus_a.cmp_rs1_o) < $signed(bus_a.cmp_rs2_o));
    assign bus_b.cmp_equal_i = (bus_b.cmp_rs1_o == bus_b.cmp_rs2_o);
    assign bus_b.cmp_less_i  = bus_b.cmp_unsign_o ? (bus_b.cmp_rs1_o < bus_b.cmp_rs2_o)
                                                  : ($signed(bus_b.cmp_rs1_o) < $signed(bus_b.cmp_rs2_o));

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        link_we;
        logic [31:0] link;
        logic        misalign;
        logic        illegal;
        int          flush;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rpc  = 32'h0;
    logic [31:0] last_link = 32'h0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    int          chk_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t        e;
        logic [31:0] tgt;
        logic        tk, ill, mis;
        tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        ill = br && (f3 == 3'b010 || f3 == 3'b011);
        case (f3)
            3'b000:  tk = (rs1 == rs2);
            3'b001:  tk = (rs1 != rs2);
            3'b100:  tk = ($signed(rs1) < $signed(rs2));
            3'b101:  tk = !($signed(rs1) < $signed(rs2));
            3'b110:  tk = (rs1 < rs2);
            3'b111:  tk = !(rs1 < rs2);
            default: tk = 1'b0;
        endcase
        if (jal || jalr) tk = 1'b1;
        if (ill) tk = 1'b0;
        mis = tk && (tgt[1:0] != 2'b00);
        if (tk) last_rpc = tgt;
        e.redirect = tk && !mis;
        e.link_we  = tk && !mis && (jal || jalr);
        if (e.link_we) last_link = pc + 32'd4;
        e.rpc      = last_rpc;
        e.link     = last_link;
        e.misalign = mis;
        e.illegal  = ill;
        e.flush    = e.redirect ? 2 : 0;
        sb.push_back(e);
    endtask

    task automatic set_a(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus_a.is_branch_i = br;
        bus_a.is_jal_i    = jal;
        bus_a.is_jalr_i   = jalr;
        bus_a.funct3_i    = f3;
        bus_a.pc_i        = pc;
        bus_a.imm_i       = imm;
        bus_a.rs1_data_i  = rs1;
        bus_a.rs2_data_i  = rs2;
        bus_a.valid_i     = 1'b1;
    endtask

    // Issue at a negedge where ready_o is high; returns at the EVAL-cycle negedge.
    task automatic send_a(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2);
        int n = 0;
        while (!bus_a.ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        set_a(br, jal, jalr, f3, pc, imm, rs1, rs2);
        push_exp(br, jal, jalr, f3, pc, imm, rs1, rs2);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        int   n = 0;
        int   f = 0;
        chk({tag, "_eval_busy"}, {30'h0, bus_a.resolved_o, bus_a.ready_o}, 32'h0);
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.resolved_o && n < 4);
        chk({tag, "_latency"}, n, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_redirect"}, {31'h0, bus_a.redirect_o}, {31'h0, e.redirect});
        chk({tag, "_rpc"}, bus_a.redirect_pc_o, e.rpc);
        chk({tag, "_link_we"}, {31'h0, bus_a.link_we_o}, {31'h0, e.link_we});
        chk({tag, "_link"}, bus_a.link_o, e.link);
        chk({tag, "_misalign"}, {31'h0, bus_a.misalign_o}, {31'h0, e.misalign});
        chk({tag, "_illegal"}, {31'h0, bus_a.illegal_o}, {31'h0, e.illegal});
        while (bus_a.flush_o && f < 10) begin
            f++;
            @(negedge clk);
            if (f == 1) chk({tag, "_pulse_once"}, {31'h0, bus_a.resolved_o}, 32'h0);
        end
        chk({tag, "_flush_len"}, f, e.flush);
        chk({tag, "_ready_back"}, {31'h0, bus_a.ready_o}, 32'h1);
    endtask

    initial begin
        int f;
        bus_a.valid_i = 1'b0; bus_a.kill_i = 1'b0; bus_a.is_branch_i = 1'b0;
        bus_a.is_jal_i = 1'b0; bus_a.is_jalr_i = 1'b0; bus_a.funct3_i = 3'h0;
        bus_a.pc_i = 32'h0; bus_a.imm_i = 32'h0; bus_a.rs1_data_i = 32'h0; bus_a.rs2_data_i = 32'h0;
        bus_b.valid_i = 1'b0; bus_b.kill_i = 1'b0; bus_b.is_branch_i = 1'b0;
        bus_b.is_jal_i = 1'b0; bus_b.is_jalr_i = 1'b0; bus_b.funct3_i = 3'h0;
        bus_b.pc_i = 32'h0; bus_b.imm_i = 32'h0; bus_b.rs1_data_i = 32'h0; bus_b.rs2_data_i = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_redirect", {31'h0, bus_a.redirect_o}, 32'h0);
        chk("rst_rpc", bus_a.redirect_pc_o, 32'h0);
        chk("rst_link", bus_a.link_o, 32'h0);
        chk("rst_flush", {31'h0, bus_a.flush_o}, 32'h0);
        chk("rst_cmp_rs1", bus_a.cmp_rs1_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, bus_a.ready_o}, 32'h1);

        send_a(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
        expect_out("beq");
        send_a(1'b1, 1'b0, 1'b0, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
        expect_out("blt");
        send_a(1'b1, 1'b0, 1'b0, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
        expect_out("bltu");
        send_a(1'b0, 1'b0, 1'b1, 3'b000, 32'h200, 32'h0, 32'h1003, 32'h0);
        expect_out("jalr_mis");
        send_a(1'b0, 1'b1, 1'b0, 3'b000, 32'h7FFF_FFFC, 32'h8, 32'h0, 32'h0);
        expect_out("jal_wrap");
        send_a(1'b1, 1'b0, 1'b0, 3'b111, 32'h500, 32'h10, 32'd3, 32'hFFFF_FFFF);
        expect_out("bgeu");
        send_a(1'b1, 1'b0, 1'b0, 3'b010, 32'h600, 32'h10, 32'd1, 32'd1);
        expect_out("illegal");
        // Issued immediately at the resolve cycle: latency check shows it was taken at once
        send_a(1'b1, 1'b0, 1'b0, 3'b001, 32'h700, 32'h10, 32'd9, 32'd9);
        expect_out("bne_after_ill");

        // kill during EVAL of a taken BNE
        set_a(1'b1, 1'b0, 1'b0, 3'b001, 32'h800, 32'h10, 32'd1, 32'd2);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        bus_a.kill_i  = 1'b1;
        @(negedge clk);
        bus_a.kill_i = 1'b0;
        chk("kill_eval_pulses", {28'h0, bus_a.redirect_o, bus_a.resolved_o, bus_a.flush_o,
                                 bus_a.link_we_o}, 32'h0);
        chk("kill_eval_rpc", bus_a.redirect_pc_o, last_rpc);
        chk("kill_eval_ready", {31'h0, bus_a.ready_o}, 32'h1);

        // kill beats valid in IDLE
        set_a(1'b0, 1'b1, 1'b0, 3'b000, 32'h900, 32'h10, 32'h0, 32'h0);
        bus_a.kill_i = 1'b1;
        @(negedge clk);
        chk("kill_idle_ready", {31'h0, bus_a.ready_o}, 32'h1);
        bus_a.valid_i = 1'b0;
        bus_a.kill_i  = 1'b0;

        // reset during FLUSH, valid held through reset
        set_a(1'b1, 1'b0, 1'b0, 3'b000, 32'h400, 32'h10, 32'd7, 32'd7);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        @(negedge clk);
        chk("rstf_redirect", {31'h0, bus_a.redirect_o}, 32'h1);
        rst_n = 1'b0;
        set_a(1'b0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstf_outs", {27'h0, bus_a.redirect_o, bus_a.flush_o, bus_a.resolved_o,
                          bus_a.link_we_o, bus_a.misalign_o}, 32'h0);
        chk("rstf_rpc", bus_a.redirect_pc_o, 32'h0);
        chk("rstf_cmp_rs1", bus_a.cmp_rs1_o, 32'h0);
        last_rpc  = 32'h0;
        last_link = 32'h0;
        rst_n = 1'b1;
        push_exp(1'b0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        expect_out("post_rst_jal");

        // FLUSH_CYCLES=3 instance: kill in first flush cycle
        bus_b.is_jal_i = 1'b1;
        bus_b.pc_i     = 32'h0;
        bus_b.imm_i    = 32'h10;
        bus_b.valid_i  = 1'b1;
        @(negedge clk);
        bus_b.valid_i = 1'b0;
        @(negedge clk);
        chk("b_redirect", {30'h0, bus_b.redirect_o, bus_b.flush_o}, 32'h3);
        chk("b_rpc", bus_b.redirect_pc_o, 32'h10);
        bus_b.kill_i = 1'b1;
        @(negedge clk);
        bus_b.kill_i = 1'b0;
        chk("b_kill_flush", {30'h0, bus_b.flush_o, bus_b.ready_o}, 32'h1);

        // same instance, uninterrupted flush runs three cycles
        bus_b.pc_i    = 32'h20;
        bus_b.imm_i   = 32'h20;
        bus_b.valid_i = 1'b1;
        @(negedge clk);
        bus_b.valid_i = 1'b0;
        @(negedge clk);
        f = 0;
        while (bus_b.flush_o && f < 10) begin
            f++;
            @(negedge clk);
        end
        chk("b_flush_len", f, 3);
        chk("b_link", bus_b.link_o, 32'h24);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
